exu_wb_arb: RTL

- Writeback arbiter that sits directly downstream of the EXU functional units (ALU, MUL, DIV, LSU) and upstream of the IDU1 register-file write port.
- Each unit's writeback is captured in its own small FIFO. One entry per cycle is granted round-robin, and a single registered-free writeback stream drives the regfile.
- It replaces the OR-mux merge, which cannot tolerate two units completing in the same cycle.
- It provides per-unit almost-full back-pressure so IDU1 can hold issue.

---
 rtl/exu_wb_arb_pkg.sv | 22 ++
 rtl/exu_wb_arb_wb_fifo.sv | 79 +++++++
 rtl/exu_wb_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/exu_wb_arb_pkg.sv
// Shared types and constants for the EXU writeback arbiter.
package exu_wb_arb_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int INSTR_W = 32;

  // Fixed source indices of the writeback ports.
  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MUL = 2'd1;
  localparam logic [1:0] WB_SRC_DIV = 2'd2;
  localparam logic [1:0] WB_SRC_LSU = 2'd3;

  // One queued writeback: result, destination and debug trace fields.
  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [REG_W-1:0]   rd_addr;
    logic [XLEN-1:0]    tag;
    logic [INSTR_W-1:0] instr;
  } exu_wb_req_t;

endpackage

// File: rtl/exu_wb_arb_wb_fifo.sv
// Per-source writeback FIFO. A push into a full FIFO is dropped unless the
// head is popped in the same cycle, in which case both take effect.
module wb_fifo
  import exu_wb_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  exu_wb_req_t       din_i,
  output exu_wb_req_t       head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              afull_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  exu_wb_req_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             afull_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // Control state; almost-full is registered from the next-state count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= (count_d >= CNT_W'(DEPTH - 1));
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; validity is tracked by the
    // count, and the consumer gates the head whenever the FIFO is empty.
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign afull_o = afull_q;

endmodule

// File: rtl/exu_wb_arb.sv
// Round-robin writeback arbiter: one FIFO per EXU unit, one regfile write per
// cycle taken from the FIFO heads, with per-unit almost-full back-pressure.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter  int NSRC  = 4,
  parameter  int DEPTH = 2,
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*XLEN-1:0]    src_data,
  input  logic [NSRC*REG_W-1:0]   src_rd_addr,
  input  logic [NSRC*XLEN-1:0]    src_tag,
  input  logic [NSRC*INSTR_W-1:0] src_instr,
  output logic [NSRC-1:0]         src_afull,
  output logic                    wb_rd_wr_en,
  output logic [XLEN-1:0]         wb_data,
  output logic [REG_W-1:0]        wb_rd_addr,
  output logic [XLEN-1:0]         wb_tag,
  output logic [INSTR_W-1:0]      wb_instr,
  output logic [SRC_W-1:0]        wb_src,
  output logic                    err_overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  exu_wb_req_t      head [NSRC];
  logic [NSRC-1:0]  full;
  logic [NSRC-1:0]  nonempty;
  logic [NSRC-1:0]  pop;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] winner;
  logic             grant;
  logic             err_q, err_d;

  function automatic logic [SRC_W-1:0] rr_add(input logic [SRC_W-1:0] base, input int off);
    return SRC_W'((int'(base) + off) % NSRC);
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    exu_wb_req_t      push_req;
    logic [CNT_W-1:0] count;

    assign push_req = '{data:    src_data[i*XLEN +: XLEN],
                        rd_addr: src_rd_addr[i*REG_W +: REG_W],
                        tag:     src_tag[i*XLEN +: XLEN],
                        instr:   src_instr[i*INSTR_W +: INSTR_W]};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (src_valid[i]),
      .pop_i   (pop[i]),
      .din_i   (push_req),
      .head_o  (head[i]),
      .count_o (count),
      .full_o  (full[i]),
      .afull_o (src_afull[i])
    );

    assign nonempty[i] = (count != '0);
  end

  // Pick the first non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    grant  = 1'b0;
    winner = rr_ptr_q;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant && nonempty[rr_add(rr_ptr_q, k)]) begin
        grant  = 1'b1;
        winner = rr_add(rr_ptr_q, k);
      end
    end
  end

  // Drive the writeback port from the winner's head and pop it; zero when idle.
  always_comb begin
    pop         = '0;
    wb_rd_wr_en = 1'b0;
    wb_src      = '0;
    wb_data     = '0;
    wb_rd_addr  = '0;
    wb_tag      = '0;
    wb_instr    = '0;
    if (grant) begin
      pop[winner] = 1'b1;
      wb_rd_wr_en = 1'b1;
      wb_src      = winner;
      wb_data     = head[winner].data;
      wb_rd_addr  = head[winner].rd_addr;
      wb_tag      = head[winner].tag;
      wb_instr    = head[winner].instr;
    end
  end

  // The pointer advances past the winner only when something retires; a push
  // into a full FIFO that is not being drained this cycle is an overflow.
  assign rr_ptr_d = grant ? rr_add(winner, 1) : rr_ptr_q;
  assign err_d    = err_q | (|(src_valid & full & ~pop));

  // Round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_overflow = err_q;

endmodule
